// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/execute/memory datapath.
package mips_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;

    // Opcodes, instruction [31:26]
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes, instruction [5:0]
    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_NOR = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    // ALU operation select
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_alu32.sv
// 32-bit ALU (EX stage); purely combinational, no overflow detection.
module mips_alu32
    import mips_pkg::*;
(
    input  logic [ALUOP_W-1:0] ctl,
    input  logic [WORD_W-1:0]  a,
    input  logic [WORD_W-1:0]  b,
    output logic [WORD_W-1:0]  result,
    output logic               zero
);

    // Operation select; undefined codes yield 0 so Zero reads high.
    always_comb begin
        result = '0;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = WORD_W'($signed(a) < $signed(b));
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_ctrl_dec.sv
// Main control decoder (ID stage); purely combinational.
module mips_ctrl_dec
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src,
    output logic               mem_write,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               j_to_pc,
    output logic               branch,
    output logic [ALUOP_W-1:0] alu_op
);

    // Decode opcode/funct; unknown opcodes fall through as a NOP with ADD.
    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        j_to_pc    = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_J: begin
                j_to_pc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_dmem.sv
// Data memory (MEM stage): async read, rising-edge write, async clear.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int unsigned DM_WORDS = 128
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DM_WORDS];

    // Reset wipes every word at once; otherwise write on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DM_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = (read && !rst) ? mem[addr] : '0;

endmodule

// File: rtl/mips_exec_mem_unit.sv
// Decode/execute/memory datapath slice: control decoder, ALU and data memory
// on independent ports so each pipeline stage wires only its own part.
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int unsigned DM_WORDS = 128
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        JToPC,
    output logic        Branch,
    output logic [3:0]  ALUOp,
    input  logic [3:0]  ALU_ctl,
    input  logic [31:0] ALU_A,
    input  logic [31:0] ALU_B,
    output logic [31:0] ALU_result,
    output logic        Zero,
    input  logic        DM_write,
    input  logic        DM_read,
    input  logic [6:0]  DM_addr,
    input  logic [31:0] DM_wdata,
    output logic [31:0] DM_rdata
);

    mips_ctrl_dec u_ctrl (
        .opcode     (Opcode),
        .funct      (Funct),
        .reg_dst    (RegDst),
        .reg_write  (RegWrite),
        .alu_src    (ALUSrc),
        .mem_write  (MemWrite),
        .mem_read   (MemRead),
        .mem_to_reg (MemToReg),
        .j_to_pc    (JToPC),
        .branch     (Branch),
        .alu_op     (ALUOp)
    );

    mips_alu32 u_alu (
        .ctl    (ALU_ctl),
        .a      (ALU_A),
        .b      (ALU_B),
        .result (ALU_result),
        .zero   (Zero)
    );

    mips_dmem #(.DM_WORDS(DM_WORDS)) u_dmem (
        .clk   (CLK),
        .rst   (RST),
        .write (DM_write),
        .read  (DM_read),
        .addr  (DM_addr),
        .wdata (DM_wdata),
        .rdata (DM_rdata)
    );

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Bench for mips_exec_mem_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_mips_exec_mem_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Opcode, Funct;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch;
    logic [3:0]  ALUOp, ALU_ctl;
    logic [31:0] ALU_A, ALU_B, ALU_result;
    logic        Zero;
    logic        DM_write, DM_read;
    logic [6:0]  DM_addr;
    logic [31:0] DM_wdata, DM_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_mem [128];

    mips_exec_mem_unit #(.DM_WORDS(128)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg), .JToPC(JToPC), .Branch(Branch),
        .ALUOp(ALUOp), .ALU_ctl(ALU_ctl), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_result(ALU_result), .Zero(Zero), .DM_write(DM_write), .DM_read(DM_read),
        .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Control word {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,JToPC,Branch,ALUOp}
    function automatic logic [11:0] m_dec(input logic [5:0] op, input logic [5:0] fn);
        logic [7:0] f;
        logic [3:0] a;
        f = 8'b0000_0000;
        a = 4'd2;
        if (op == 6'd0) begin
            f = 8'b1100_0000;
            if      (fn == 6'd32) a = 4'd2;
            else if (fn == 6'd34) a = 4'd6;
            else if (fn == 6'd36) a = 4'd0;
            else if (fn == 6'd37) a = 4'd1;
            else if (fn == 6'd39) a = 4'd12;
            else if (fn == 6'd42) a = 4'd7;
            else f = 8'b1000_0000;
        end
        else if (op == 6'd35) f = 8'b0110_1100;
        else if (op == 6'd43) f = 8'b0011_0000;
        else if (op == 6'd4)  begin f = 8'b0000_0001; a = 4'd6; end
        else if (op == 6'd8)  f = 8'b0110_0000;
        else if (op == 6'd2)  f = 8'b0000_0010;
        return {f, a};
    endfunction

    // ALU by integer arithmetic on 64-bit values
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        longint m;
        m  = 64'h1_0000_0000;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - m : ua;
        sb = b[31] ? ub - m : ub;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((ua + ub) % m);
            4'd6:  return 32'((ua + m - ub) % m);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Memory model: async clear, edge write gated by reset
    always @(posedge RST) begin
        for (int i = 0; i < 128; i++) exp_mem[i] = 32'd0;
    end

    always @(posedge CLK) begin
        if (!RST && DM_write) exp_mem[DM_addr] = DM_wdata;
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge CLK) begin
        logic [31:0] er;
        er = m_alu(ALU_ctl, ALU_A, ALU_B);
        chk("ctrl", 32'({RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch, ALUOp}),
            32'(m_dec(Opcode, Funct)));
        chk("alu_result", ALU_result, er);
        chk("zero", 32'(Zero), 32'(er == 32'd0));
        chk("dm_rdata", DM_rdata, (DM_read && !RST) ? exp_mem[DM_addr] : 32'd0);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; Opcode = '0; Funct = '0; ALU_ctl = '0; ALU_A = '0; ALU_B = '0;
        DM_write = 1'b0; DM_read = 1'b0; DM_addr = '0; DM_wdata = '0;
        #1 RST = 1'b1;
        step();
        DM_read = 1'b1; DM_addr = 7'd0;
        #1 chk("reset_rdata", DM_rdata, 32'd0);
        step();
        RST = 1'b0; DM_read = 1'b0;

        // Decode sweep
        Opcode = 6'b000000; Funct = 6'h22;
        #1 chk("dec_sub", 32'({RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch, ALUOp}),
               32'b1100_0000_0110);
        Opcode = 6'b100011;
        #1 chk("dec_lw", 32'({RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch, ALUOp}),
               32'b0110_1100_0010);
        Opcode = 6'b000010;
        #1 chk("dec_j", 32'({RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch}), 32'h02);
        Opcode = 6'b111111;
        #1 chk("dec_nop", 32'({RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch}), 32'h00);

        // ALU corners
        ALU_ctl = 4'b0010; ALU_A = 32'hFFFFFFFF; ALU_B = 32'd1;
        #1 chk("add_wrap", ALU_result, 32'd0);
        chk("add_zero", 32'(Zero), 32'd1);
        ALU_ctl = 4'b0110; ALU_A = 32'd5; ALU_B = 32'd7;
        #1 chk("sub_neg", ALU_result, 32'hFFFFFFFE);
        chk("sub_zero", 32'(Zero), 32'd0);
        ALU_ctl = 4'b0111; ALU_A = 32'hFFFFFFFF; ALU_B = 32'd1;
        #1 chk("slt_signed", ALU_result, 32'd1);
        ALU_ctl = 4'b1100; ALU_A = 32'd0; ALU_B = 32'd0;
        #1 chk("nor_zero", ALU_result, 32'hFFFFFFFF);

        // Memory round trip
        step();
        DM_write = 1'b1; DM_addr = 7'd5; DM_wdata = 32'hDEADBEEF; DM_read = 1'b0;
        #1 chk("rdata_noread", DM_rdata, 32'd0);
        step();
        DM_write = 1'b0; DM_read = 1'b1;
        #1 chk("roundtrip", DM_rdata, 32'hDEADBEEF);

        // Read/write collision
        step();
        DM_write = 1'b1; DM_addr = 7'd3; DM_wdata = 32'h11;
        step();
        DM_wdata = 32'h22;
        #1 chk("collide_before", DM_rdata, 32'h11);
        step();
        chk("collide_after", DM_rdata, 32'h22);
        DM_write = 1'b0;

        // Asynchronous reset mid-cycle
        step();
        DM_write = 1'b1; DM_addr = 7'd127; DM_wdata = 32'hA5A5A5A5; DM_read = 1'b0;
        step();
        DM_write = 1'b0; DM_read = 1'b1;
        #1 chk("addr127", DM_rdata, 32'hA5A5A5A5);
        #1 RST = 1'b1;
        #1 chk("async_clear", DM_rdata, 32'd0);
        DM_write = 1'b1; DM_wdata = 32'h12345678;
        step();
        RST = 1'b0; DM_write = 1'b0;
        #1 chk("write_in_reset", DM_rdata, 32'd0);

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            step();
            RST = 1'b0;
            case ($urandom_range(0, 7))
                0: Opcode = 6'b000000;
                1: Opcode = 6'b100011;
                2: Opcode = 6'b101011;
                3: Opcode = 6'b000100;
                4: Opcode = 6'b001000;
                5: Opcode = 6'b000010;
                default: Opcode = 6'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: Funct = 6'h20;
                1: Funct = 6'h22;
                2: Funct = 6'h24;
                3: Funct = 6'h25;
                4: Funct = 6'h27;
                5: Funct = 6'h2A;
                default: Funct = 6'($urandom);
            endcase
            ALU_ctl = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                      ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'b0110;
            ALU_A = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
            ALU_B = ($urandom_range(0, 5) == 0) ? ALU_A : $urandom;
            DM_write = 1'($urandom);
            DM_read  = ($urandom_range(0, 3) != 0);
            DM_addr  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
            DM_wdata = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #2 RST = 1'b1;
            end
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
